systolic_sched: RTL
===================

Name: systolic_sched

Overview:
- Sequencer for an N×N output-stationary systolic array of FP8 E4M3 MAC PEs. Each PE has an 18-bit accumulator and a combinational BF16 c_out.
- For each job the block clears all accumulators and streams K operand pairs from the operand buffer, skewing the west (A) and north (B) edges.
- It then zero-flushes the array until every PE holds its final dot product, and signals the result-capture logic.
- It sits between the operand buffer read port and the array edge inputs.

Parameters:
- N, 4, array dimension; number of west lanes and north lanes.
- KMAX, 256, maximum supported k_len.
- KW, 9, width of k_len and op_rd_idx; must satisfy 2^KW > KMAX.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- k_len  in  KW  dot-product length; sampled with start; valid range 0..KMAX.
- op_rd_en  out  1  operand buffer read enable; read latency is 1 cycle.
- op_rd_idx  out  KW  k index to read.
- a_col_data  in  N*8  A[i][k] in lane i, returned one cycle after op_rd_en.
- b_row_data  in  N*8  B[k][j] in lane j, returned one cycle after op_rd_en.
- pe_clear  out  1  broadcast clear to every PE.
- arr_a_west  out  N*8  skewed A to the west edge; lane i feeds row i.
- arr_b_north  out  N*8  skewed B to the north edge; lane j feeds column j.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse marking job completion.
- res_valid  out  1  array c_out values are final and stable.

Behaviour:
- Reset values: state=IDLE; all outputs 0; skew registers 0; res_valid 0.
- States and transitions:
  - IDLE: on start go to CLEAR.
  - CLEAR: 1 cycle, pe_clear=1; then go to FEED, or to FLUSH if k_len==0.
  - FEED: k_len cycles; op_rd_en=1, op_rd_idx=0..k_len-1 incrementing; then go to FLUSH.
  - FLUSH: exactly 2N-1 cycles; then go to DONE.
  - DONE: 1 cycle; done=1; res_valid set; then go to IDLE.
- Data valid: a registered copy of op_rd_en (rd_v) marks the returned data as valid.
  - When rd_v=0, lanes are forced to 8'h00; FP8 zero contributes exactly 0 to an accumulator.
- Skew: lane i (A) and lane j (B) are delayed i and j cycles respectively through zero-reset shift registers.
  - Lane 0 passes through combinationally.
  - Total register count is N(N-1)/2 per edge.
- Timing: let S be the cycle start is sampled.
  - Operand k reaches PE(i,j) in cycle S+3+k+i+j.
  - The last product lands in cycle S+1+k_len+2N.
  - done pulses in cycle S+k_len+2N+1; N=4, k_len=8 gives done at S+17.
  - For k_len=0, done pulses at S+2N+1.
- After FLUSH, edges and skew registers are all zero, so c_out = acc and is stable.
- res_valid stays high through IDLE. It is cleared in the cycle start is accepted, i.e. the CLEAR entry.
- start while busy is ignored; it is neither queued nor sampled.
- start is accepted in IDLE only, so a start asserted in the DONE cycle is ignored. Back-to-back jobs need start in the cycle after done; that job then clears the array.
- k_len > KMAX: behaviour is undefined; the bench must not drive it.
- rst_n asserted mid-job immediately returns outputs and skew registers to reset values. No done is issued, and PE contents are unspecified until the next CLEAR.
- op_rd_idx holds its last value when op_rd_en=0.

Optional Feature:
- Macro: SYSTOLIC_SCHED_PERF_EN.
- When defined:
  - Adds output perf_busy_cycles (32 bits), incremented every cycle busy=1 and saturating at 32'hFFFFFFFF.
  - Adds output perf_jobs (16 bits), incremented on each done pulse and wrapping.
  - Both reset to 0 on rst_n only.
- When undefined: neither the ports nor the logic exist; all other behaviour is identical.

Test Plan:
- N=4, k_len=8, all A and B = 8'h38 (1.0). Expect done at S+17, every c_out = 16'h4100 (8.0), res_valid=1 afterwards.
- A = 4×4 identity of 8'h38 (k_len=4), B all 8'h40 (2.0). Expect every c_out = 16'h4000.
- k_len=0. Expect CLEAR, then FLUSH for 7 cycles, then done at S+9; op_rd_en never asserted; all c_out = 16'h0000.
- start pulsed during FEED. Expect it ignored: a single done, op_rd_idx sequence 0..k_len-1 exactly once.
- rst_n low in the 3rd FEED cycle, then released, then a new start with k_len=8. Expect outputs at reset values during reset and correct 16'h4100 results from the new job.
- Skew check: with a distinct value per lane, lane i appears on arr_a_west exactly i cycles after lane 0.
  - Also check that lanes read 8'h00 whenever rd_v=0.

Source files
------------

// File: rtl/systolic_sched.sv
// Job sequencer for an NxN output-stationary FP8 systolic array: clear, skewed operand feed, zero-flush, done.
// Optional perf counters (perf_busy_cycles, perf_jobs) are built when SYSTOLIC_SCHED_PERF_EN is defined.
module systolic_sched #(
  parameter int N    = 4,
  parameter int KMAX = 256,
  parameter int KW   = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [KW-1:0]  k_len,
  output logic           op_rd_en,
  output logic [KW-1:0]  op_rd_idx,
  input  logic [N*8-1:0] a_col_data,
  input  logic [N*8-1:0] b_row_data,
  output logic           pe_clear,
  output logic [N*8-1:0] arr_a_west,
  output logic [N*8-1:0] arr_b_north,
  output logic           busy,
  output logic           done,
`ifdef SYSTOLIC_SCHED_PERF_EN
  output logic [31:0]    perf_busy_cycles,
  output logic [15:0]    perf_jobs,
`endif
  output logic           res_valid
);

  localparam int FW = $clog2(2 * N);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 2);

  if ((2 ** KW) <= KMAX) begin : g_bad_kw
    $error("KW too narrow to hold KMAX");
  end

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DONE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_len_q, k_len_d;
  logic [KW-1:0] op_rd_idx_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          res_valid_d, rd_v_q, rd_v_d;

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    op_rd_idx_d = op_rd_idx;
    fcnt_d      = fcnt_q;
    rd_v_d      = op_rd_en;
    case (state_q)
      IDLE:  if (start) begin
               state_d = CLEAR;
               k_len_d = k_len;
             end
      CLEAR: if (k_len_q == '0) state_d = FLUSH;
             else begin
               state_d     = FEED;
               op_rd_idx_d = '0;
             end
      FEED:  if (op_rd_idx == k_len_q - KW'(1)) state_d = FLUSH;
             else op_rd_idx_d = op_rd_idx + KW'(1);
      FLUSH: if (fcnt_q == FLUSH_LAST) state_d = DONE;
             else fcnt_d = fcnt_q + FW'(1);
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == FLUSH && state_q != FLUSH) fcnt_d = '0;
    // res_valid is sticky from DONE until the next job's CLEAR
    res_valid_d = res_valid;
    if (state_d == DONE)       res_valid_d = 1'b1;
    else if (state_d == CLEAR) res_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_len_q   <= '0;
      op_rd_idx <= '0;
      fcnt_q    <= '0;
      res_valid <= 1'b0;
      pe_clear  <= 1'b0;
      op_rd_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_v_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_len_q   <= k_len_d;
      op_rd_idx <= op_rd_idx_d;
      fcnt_q    <= fcnt_d;
      res_valid <= res_valid_d;
      pe_clear  <= (state_d == CLEAR);
      op_rd_en  <= (state_d == FEED);
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);
      rd_v_q    <= rd_v_d;
    end
  end

  // Unread cycles present FP8 zero so flushing never disturbs the accumulators
  logic [7:0] a_lane [N];
  logic [7:0] b_lane [N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_lane[i] = rd_v_q ? a_col_data[i*8 +: 8] : 8'h00;
      b_lane[i] = rd_v_q ? b_row_data[i*8 +: 8] : 8'h00;
    end
  end

  assign arr_a_west[7:0]  = a_lane[0];
  assign arr_b_north[7:0] = b_lane[0];

  for (genvar g = 1; g < N; g++) begin : g_skew
    logic [7:0] a_sr_q [g];
    logic [7:0] a_sr_d [g];
    logic [7:0] b_sr_q [g];
    logic [7:0] b_sr_d [g];

    always_comb begin
      a_sr_d[0] = a_lane[g];
      b_sr_d[0] = b_lane[g];
      for (int d = 1; d < g; d++) begin
        a_sr_d[d] = a_sr_q[d-1];
        b_sr_d[d] = b_sr_q[d-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int d = 0; d < g; d++) begin
          a_sr_q[d] <= 8'h00;
          b_sr_q[d] <= 8'h00;
        end
      end else begin
        a_sr_q <= a_sr_d;
        b_sr_q <= b_sr_d;
      end
    end

    assign arr_a_west[g*8 +: 8]  = a_sr_q[g-1];
    assign arr_b_north[g*8 +: 8] = b_sr_q[g-1];
  end

`ifdef SYSTOLIC_SCHED_PERF_EN
  logic [31:0] perf_busy_cycles_d;
  logic [15:0] perf_jobs_d;

  always_comb begin
    perf_busy_cycles_d = perf_busy_cycles;
    if (busy && perf_busy_cycles != 32'hFFFF_FFFF) perf_busy_cycles_d = perf_busy_cycles + 32'd1;
    perf_jobs_d = done ? perf_jobs + 16'd1 : perf_jobs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles <= '0;
      perf_jobs        <= '0;
    end else begin
      perf_busy_cycles <= perf_busy_cycles_d;
      perf_jobs        <= perf_jobs_d;
    end
  end
`endif

endmodule
